ifetch: RTL and testbench

Instruction fetch stage: the producer of the `pc`/`is` pair consumed by the decode stage, and the consumer of its jump target `npc`. Reads one 32-bit little-endian instruction as four byte reads over a byte-wide, arbitrated memory port and presents it to decode for one cycle, or longer if the pipeline stalls. It restarts at a redirect target when decode or a later stage signals a taken jump. An all-zero `is` is a bubble (NOP) to decode.

---
 rtl/ifetch.sv | 160 ++++++++++++++++
 tb/tb_ifetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage.
// Assembles one 32-bit little-endian instruction from four byte reads on an
// arbitrated byte-wide memory port and presents it to decode as the is/pc pair.
// Restarts at npc whenever npc_e is seen at an edge.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   stall    in   pipeline stall; freezes FSM and outputs, pending byte still captured
//   npc      in   redirect target
//   npc_e    in   redirect strobe, highest priority
//   mem_req  out  byte read request (from registered state only, gated by rst)
//   mem_a    out  byte address fa + cnt
//   mem_gnt  in   arbiter grant; req & gnt = accepted
//   mem_din  in   read data, valid the cycle after acceptance
//   pc       out  address of presented instruction + 4
//   is       out  presented instruction; 0 = bubble
module ifetch #(
    parameter logic [31:0] RST_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] npc,
    input  logic        npc_e,
    output logic        mem_req,
    output logic [31:0] mem_a,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic [31:0] pc,
    output logic [31:0] is
);

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StLast  = 2'd1,
        StHold  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fa_q, fa_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;   // bytes 0..2 of the word being assembled
    logic [7:0]  b3_q, b3_d;     // byte 3, kept if LAST is stretched by stall
    logic [31:0] is_q, is_d;
    logic [31:0] pc_q, pc_d;
    logic        pres_q, pres_d; // is/pc currently show a freshly completed word

    logic        accept;
    logic [7:0]  byte3;

    // Stalled or redirected cycles do not take ownership of a granted byte;
    // the address is simply requested again later.
    assign accept = (state_q == StFetch) && mem_gnt && !stall && !npc_e;

    // Byte 3 arrives live in the first LAST cycle, otherwise it was parked in b3_q.
    assign byte3 = (inflight_q && (lane_q == 2'd3)) ? mem_din : b3_q;

    always_comb begin
        state_d    = state_q;
        fa_d       = fa_q;
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        b3_d       = b3_q;
        is_d       = is_q;
        pc_d       = pc_q;
        pres_d     = pres_q;

        // Capture of a pending byte happens in every cycle, stalled or not.
        if (inflight_q) begin
            unique case (lane_q)
                2'd0:    asm_d[7:0]   = mem_din;
                2'd1:    asm_d[15:8]  = mem_din;
                2'd2:    asm_d[23:16] = mem_din;
                default: b3_d         = mem_din;
            endcase
            inflight_d = 1'b0;
        end

        if (npc_e) begin
            fa_d       = npc;
            cnt_d      = 2'd0;
            inflight_d = 1'b0;
            is_d       = 32'h0;
            pres_d     = 1'b0;
            state_d    = StFetch;
        end else if (stall) begin
            // Only a stalled presentation parks in HOLD; a stalled fetch just waits.
            if ((state_q == StFetch) && pres_q) begin
                state_d = StHold;
            end
        end else begin
            is_d   = 32'h0;
            pres_d = 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (accept) begin
                        inflight_d = 1'b1;
                        lane_d     = cnt_q;
                        cnt_d      = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = StLast;
                        end
                    end
                end
                StLast: begin
                    is_d       = {byte3, asm_q};
                    pc_d       = fa_q + 32'd4;
                    fa_d       = fa_q + 32'd4;
                    cnt_d      = 2'd0;
                    inflight_d = 1'b0;
                    pres_d     = 1'b1;
                    state_d    = StFetch;
                end
                StHold: begin
                    state_d = StFetch;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StFetch;
            fa_q       <= RST_PC;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            lane_q     <= 2'd0;
            asm_q      <= 24'h0;
            b3_q       <= 8'h0;
            is_q       <= 32'h0;
            pc_q       <= 32'h0;
            pres_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fa_q       <= fa_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            b3_q       <= b3_d;
            is_q       <= is_d;
            pc_q       <= pc_d;
            pres_q     <= pres_d;
        end
    end

    assign mem_req = rst && (state_q == StFetch);
    assign mem_a   = rst ? (fa_q + {30'b0, cnt_q}) : 32'h0;
    assign pc      = pc_q;
    assign is      = is_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: table vectors, directed multi-cycle sequences and a randomized run
// of ifetch against a byte-counting reference model and a behavioural memory.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] npc;
    logic        npc_e;
    logic        mem_req;
    logic [31:0] mem_a;
    logic        mem_gnt;
    logic [7:0]  mem_din;
    logic [31:0] pc;
    logic [31:0] is;

    ifetch #(.RST_PC(RST_PC)) dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .npc     (npc),
        .npc_e   (npc_e),
        .mem_req (mem_req),
        .mem_a   (mem_a),
        .mem_gnt (mem_gnt),
        .mem_din (mem_din),
        .pc      (pc),
        .is      (is)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory contents: fixed test word at 0..3, address hash elsewhere.
    function automatic logic [7:0] memb(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {memb(a + 32'd3), memb(a + 32'd2), memb(a + 32'd1), memb(a)};
    endfunction

    // Data for an accepted request shows up next cycle; otherwise garbage.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) mem_din <= memb(mem_a);
        else                    mem_din <= 8'($urandom);
    end

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: the fetch stream is m_base + (bytes accepted since base).
    // A word completes on its 4th accepted byte, is shown after the next edge that
    // is neither stalled nor redirected, and is held across stalled edges.
    logic [31:0] m_base;
    int unsigned m_nacc;
    logic        m_wait;  // word complete, waiting for release
    logic        m_pres;  // word is on is/pc
    logic        m_hold;  // presentation is being held by stall
    logic [31:0] m_is, m_pc;
    logic        chk_en = 1'b0;

    logic        s_req;
    logic [31:0] s_a, s_is, s_pc;

    task automatic cyc(input logic r, input logic g, input logic s, input logic ne,
                       input logic [31:0] n);
        logic er;
        rst = r; mem_gnt = g; stall = s; npc_e = ne; npc = n;
        @(negedge clk);
        s_req = mem_req; s_a = mem_a; s_is = is; s_pc = pc;
        er = r && !m_wait && !m_hold;
        if (chk_en) begin
            check("model_req", {31'b0, s_req}, {31'b0, er});
            if (er) check("model_a", s_a, m_base + m_nacc);
            if (!r) check("rst_a", s_a, 32'h0);
            check("model_is", s_is, m_is);
            check("model_pc", s_pc, m_pc);
        end
        if (!r) begin
            m_base = RST_PC; m_nacc = 0; m_wait = 0; m_pres = 0; m_hold = 0;
            m_is = 0; m_pc = 0;
        end else if (ne) begin
            m_base = n; m_nacc = 0; m_wait = 0; m_pres = 0; m_hold = 0; m_is = 0;
        end else if (s) begin
            if (m_pres) m_hold = 1;
        end else begin
            if (m_wait) begin
                m_pc   = m_base + m_nacc;
                m_is   = word(m_base + m_nacc - 32'd4);
                m_wait = 0;
                m_pres = 1;
            end else begin
                m_is   = 0;
                m_pres = 0;
            end
            m_hold = 0;
            if (er && g) begin
                m_nacc++;
                if (m_nacc % 4 == 0) m_wait = 1;
            end
        end
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic g, input logic s, input logic ne, input logic [31:0] n);
        cyc(1'b1, g, s, ne, n);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    typedef struct {
        logic        r, g, s, ne;
        logic [31:0] n;
        logic        er;
        logic [31:0] ea, eis, epc;
    } vec_t;

    vec_t tbl [11];
    int   got;

    initial begin
        // Basic fetch after reset with grant always high.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2, 32'h0, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3, 32'h0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 32'h00100513, 32'h4};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5, 32'h0, 32'h4};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6, 32'h0, 32'h4};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7, 32'h0, 32'h4};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].r, tbl[i].g, tbl[i].s, tbl[i].ne, tbl[i].n);
            check("tbl_req", {31'b0, s_req}, {31'b0, tbl[i].er});
            if (tbl[i].er || !tbl[i].r) check("tbl_a", s_a, tbl[i].ea);
            check("tbl_is", s_is, tbl[i].eis);
            check("tbl_pc", s_pc, tbl[i].epc);
        end

        // Grant denied on odd cycles: four extra cycles, addresses repeat.
        do_reset();
        got = 0;
        for (int c = 1; c <= 20; c++) begin
            run(c % 2 == 0, 1'b0, 1'b0, 32'h0);
            if (c == 2) check("gnt_repeat_a0", s_a, 32'h0);
            if (c == 4) check("gnt_repeat_a1", s_a, 32'h1);
            if (got == 0 && s_is != 0) begin
                got = c;
                check("gnt_is", s_is, 32'h00100513);
                check("gnt_pc", s_pc, 32'h4);
            end
        end
        check("gnt_latency", got, 10);

        // Stall for 3 cycles from the presentation cycle.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            run(1'b1, c >= 6 && c <= 8, 1'b0, 32'h0);
            if (c >= 6 && c <= 9) begin
                check("stall_is_hold", s_is, 32'h00100513);
                check("stall_pc_hold", s_pc, 32'h4);
            end
            if (c >= 7 && c <= 9) check("stall_req_low", {31'b0, s_req}, 32'h0);
            if (c == 10) begin
                check("stall_is_clr", s_is, 32'h0);
                check("stall_resume_req", {31'b0, s_req}, 32'h1);
                check("stall_resume_a", s_a, 32'h4);
            end
        end

        // Redirect to 0x100 during byte-2 acceptance.
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            run(1'b1, 1'b0, c == 3, 32'h100);
            if (c == 4) check("redir_a", s_a, 32'h100);
            if (c == 9) begin
                check("redir_is", s_is, word(32'h100));
                check("redir_pc", s_pc, 32'h104);
            end
        end

        // Redirect and stall together in LAST: redirect wins.
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            run(1'b1, c == 5, c == 5, 32'h200);
            if (c == 6) check("redir_last_a", s_a, 32'h200);
            if (c >= 6 && c <= 10) check("redir_last_drop", s_is, 32'h0);
            if (c == 11) begin
                check("redir_last_is", s_is, word(32'h200));
                check("redir_last_pc", s_pc, 32'h204);
            end
        end

        // Wrap at the top of the address space, then reset mid-fetch.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            cyc(c != 9, 1'b1, 1'b0, c == 1, 32'hFFFF_FFFC);
            if (c == 2) check("wrap_a_fc", s_a, 32'hFFFF_FFFC);
            if (c == 5) check("wrap_a_ff", s_a, 32'hFFFF_FFFF);
            if (c == 7) begin
                check("wrap_is", s_is, word(32'hFFFF_FFFC));
                check("wrap_pc", s_pc, 32'h0);
                check("wrap_next_a", s_a, 32'h0);
            end
            if (c == 9) check("rst_req", {31'b0, s_req}, 32'h0);
            if (c == 10) begin
                check("rst_is", s_is, 32'h0);
                check("rst_pc", s_pc, 32'h0);
                check("rst_restart_a", s_a, RST_PC);
            end
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 1) == 0) ? 32'($urandom)
                                               : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 30) == 0, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
